// File: rtl/riscv_tag_check_unit_pkg.sv
// Shared types for the DIFT tag-check stage: FSM states, check-enable bit positions
// and the instruction class encoding used by the class-indexed enables and counters.
package riscv_tag_check_unit_pkg;

   typedef enum logic [1:0] {
      TAG_IDLE    = 2'd0,
      TAG_TRAP    = 2'd1,
      TAG_RECOVER = 2'd2
   } tag_fsm_e;

   // Positions inside each per-class {D,S2,S1} enable triple and inside the hit vector
   localparam int CHK_S1 = 0;
   localparam int CHK_S2 = 1;
   localparam int CHK_D  = 2;

   typedef enum logic [2:0] {
      TCLASS_JUMP    = 3'd0,
      TCLASS_BRANCH  = 3'd1,
      TCLASS_LDST    = 3'd2,
      TCLASS_INT     = 3'd3,
      TCLASS_SHIFT   = 3'd4,
      TCLASS_CMP     = 3'd5,
      TCLASS_LOGICAL = 3'd6
   } tag_class_e;

endpackage

// File: rtl/riscv_tag_viol_counters.sv
// Per-class saturating violation counters with one increment port and a
// select-addressed clear/read port; a clear beats a same-cycle increment.
module riscv_tag_viol_counters
   import riscv_tag_check_unit_pkg::*;
#(
   parameter int NUM_CLASSES = 8,
   parameter int CLASS_W     = 3,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   input  logic [CLASS_W-1:0]   inc_sel,
   input  logic                 clr,
   input  logic [CLASS_W-1:0]   cnt_sel,
   output logic [CNT_WIDTH-1:0] cnt
);

   logic [CNT_WIDTH-1:0] cnt_q [NUM_CLASSES];

   // Selects outside 0..NUM_CLASSES-1 never match, so they neither clear nor read
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
         if (rst) begin
            cnt_q[c] <= '0;
         end else if (clr && (cnt_sel == CLASS_W'(c))) begin
            cnt_q[c] <= '0;
         end else if (inc && (inc_sel == CLASS_W'(c)) && (cnt_q[c] != '1)) begin
            cnt_q[c] <= cnt_q[c] + 1'b1;
         end
      end
   end

   always_comb begin
      cnt = '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
         if (cnt_sel == CLASS_W'(c)) cnt = cnt_q[c];
      end
   end

endmodule

// File: rtl/riscv_tag_check_unit.sv
// DIFT tag-check stage: registers decoded class/enables/masked tags, flags a policy
// violation one cycle later, and either traps via req/ack or only counts it.
module riscv_tag_check_unit
   import riscv_tag_check_unit_pkg::*;
#(
   parameter int TAG_WIDTH   = 4,
   parameter int NUM_CLASSES = 8,
   parameter int CLASS_W     = 3,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     instr_valid_i,
   output logic                     ready_o,
   input  logic [CLASS_W-1:0]       instr_class_i,
   input  logic [3*NUM_CLASSES-1:0] chk_en_i,
   input  logic [TAG_WIDTH-1:0]     tag_rs1_i,
   input  logic [TAG_WIDTH-1:0]     tag_rs2_i,
   input  logic [TAG_WIDTH-1:0]     tag_rd_i,
   input  logic [TAG_WIDTH-1:0]     tag_mask_i,
   input  logic                     trap_mode_i,
   input  logic                     flush_i,
   output logic                     violation_o,
   output logic                     trap_req_o,
   input  logic                     trap_ack_i,
   output logic [CLASS_W+2:0]       trap_cause_o,
   input  logic [CLASS_W-1:0]       cnt_sel_i,
   input  logic                     cnt_clr_i,
   output logic [CNT_WIDTH-1:0]     cnt_o
);

   tag_fsm_e             state_q, state_d;
   logic                 accept;
   logic [2:0]           en_sel;
   logic                 s_valid_p0;
   logic [CLASS_W-1:0]   s_class_p0;
   logic [2:0]           s_en_p0;
   logic [TAG_WIDTH-1:0] s_rs1_p0, s_rs2_p0, s_rd_p0;
   logic [2:0]           hit;
   logic                 viol;

   assign accept = instr_valid_i & ready_o;

   // Unknown classes get no enables, so they can never violate or count
   always_comb begin
      en_sel = '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
         if (instr_class_i == CLASS_W'(c)) en_sel = chk_en_i[3*c +: 3];
      end
   end

   // ---- stage p0: capture decoded instruction ----
   always_ff @(posedge clk) begin
      if (rst) s_valid_p0 <= 1'b0;
      else     s_valid_p0 <= accept & ~flush_i;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         s_class_p0 <= instr_class_i;
         s_en_p0    <= en_sel;
         s_rs1_p0   <= tag_rs1_i & tag_mask_i;
         s_rs2_p0   <= tag_rs2_i & tag_mask_i;
         s_rd_p0    <= tag_rd_i & tag_mask_i;
      end
   end

   always_comb begin
      hit         = '0;
      hit[CHK_S1] = s_en_p0[CHK_S1] & (|s_rs1_p0);
      hit[CHK_S2] = s_en_p0[CHK_S2] & (|s_rs2_p0);
      hit[CHK_D]  = s_en_p0[CHK_D]  & (|s_rd_p0);
   end

   assign viol = s_valid_p0 & (|hit);

   // ---- stage p1: report, trap FSM and cause ----
   always_ff @(posedge clk) begin
      if (rst) violation_o <= 1'b0;
      else     violation_o <= viol;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= TAG_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         TAG_IDLE:    if (viol && trap_mode_i) state_d = TAG_TRAP;
         TAG_TRAP:    if (trap_ack_i) state_d = TAG_RECOVER;
         TAG_RECOVER: state_d = TAG_IDLE;
         default:     state_d = TAG_IDLE;
      endcase
   end

   always_comb begin
      ready_o    = (state_q == TAG_IDLE);
      trap_req_o = (state_q == TAG_TRAP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         trap_cause_o <= '0;
      end else if ((state_q == TAG_IDLE) && viol && trap_mode_i) begin
         trap_cause_o <= {s_class_p0, hit};
      end
   end

   riscv_tag_viol_counters #(
      .NUM_CLASSES (NUM_CLASSES),
      .CLASS_W     (CLASS_W),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_counters (
      .clk     (clk),
      .rst     (rst),
      .inc     (viol),
      .inc_sel (s_class_p0),
      .clr     (cnt_clr_i),
      .cnt_sel (cnt_sel_i),
      .cnt     (cnt_o)
   );

endmodule

// File: tb/tb_riscv_tag_check_unit.sv
// Bench for riscv_tag_check_unit: directed cases with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_riscv_tag_check_unit;

   localparam int TW   = 4;
   localparam int NC   = 6;
   localparam int CW   = 3;
   localparam int CNTW = 16;
   localparam int CMAX = (1 << CNTW) - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            instr_valid_i = 1'b0;
   logic            ready_o;
   logic [CW-1:0]   instr_class_i = '0;
   logic [3*NC-1:0] chk_en_i = '0;
   logic [TW-1:0]   tag_rs1_i = '0, tag_rs2_i = '0, tag_rd_i = '0, tag_mask_i = '1;
   logic            trap_mode_i = 1'b0;
   logic            flush_i = 1'b0;
   logic            violation_o;
   logic            trap_req_o;
   logic            trap_ack_i = 1'b0;
   logic [CW+2:0]   trap_cause_o;
   logic [CW-1:0]   cnt_sel_i = '0;
   logic            cnt_clr_i = 1'b0;
   logic [CNTW-1:0] cnt_o;

   always #5 clk = ~clk;

   riscv_tag_check_unit #(
      .TAG_WIDTH(TW), .NUM_CLASSES(NC), .CLASS_W(CW), .CNT_WIDTH(CNTW)
   ) dut (
      .clk(clk), .rst(rst), .instr_valid_i(instr_valid_i), .ready_o(ready_o),
      .instr_class_i(instr_class_i), .chk_en_i(chk_en_i), .tag_rs1_i(tag_rs1_i),
      .tag_rs2_i(tag_rs2_i), .tag_rd_i(tag_rd_i), .tag_mask_i(tag_mask_i),
      .trap_mode_i(trap_mode_i), .flush_i(flush_i), .violation_o(violation_o),
      .trap_req_o(trap_req_o), .trap_ack_i(trap_ack_i), .trap_cause_o(trap_cause_o),
      .cnt_sel_i(cnt_sel_i), .cnt_clr_i(cnt_clr_i), .cnt_o(cnt_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Mode: 0 = accepting, 1 = trap pending, 2 = one-cycle redirect
   int       m_mode = 0;
   bit       m_pend = 0;
   int       m_pcls = 0;
   bit [2:0] m_phit = 0;
   bit       m_viol = 0;
   bit [5:0] m_cause = 0;
   int       m_cnt [8];
   bit       started = 0;

   function automatic bit [2:0] hits_of(int cls, bit [3*NC-1:0] en,
                                        bit [TW-1:0] r1, bit [TW-1:0] r2,
                                        bit [TW-1:0] rd, bit [TW-1:0] mask);
      bit [2:0] h = 0;
      if (cls >= NC) return 3'b000;
      h[0] = en[3*cls+0] && ((r1 & mask) != 0);
      h[1] = en[3*cls+1] && ((r2 & mask) != 0);
      h[2] = en[3*cls+2] && ((rd & mask) != 0);
      return h;
   endfunction

   always @(posedge clk) begin
      bit       acc_ok;
      bit [2:0] h;
      bit       v;
      int       exp_cnt;
      acc_ok = (m_mode == 0);
      if (rst) begin
         m_mode = 0; m_pend = 0; m_viol = 0; m_cause = 0;
         for (int i = 0; i < 8; i++) m_cnt[i] = 0;
         started = 1;
      end else begin
         h = m_pend ? m_phit : 3'b000;
         v = (h != 0);
         if (v && m_cnt[m_pcls] < CMAX) m_cnt[m_pcls] = m_cnt[m_pcls] + 1;
         if (cnt_clr_i && int'(cnt_sel_i) < NC) m_cnt[cnt_sel_i] = 0;
         m_viol = v;
         if (m_mode == 0) begin
            if (v && trap_mode_i) begin
               m_mode  = 1;
               m_cause = {m_pcls[2:0], h};
            end
         end else if (m_mode == 1) begin
            if (trap_ack_i) m_mode = 2;
         end else begin
            m_mode = 0;
         end
         m_pend = instr_valid_i && acc_ok && !flush_i;
         if (instr_valid_i && acc_ok) begin
            m_pcls = int'(instr_class_i);
            m_phit = hits_of(m_pcls, chk_en_i, tag_rs1_i, tag_rs2_i, tag_rd_i, tag_mask_i);
         end
      end
      #1;
      if (started) begin
         exp_cnt = (int'(cnt_sel_i) < NC) ? m_cnt[cnt_sel_i] : 0;
         check("model_violation", 32'(violation_o), 32'(m_viol));
         check("model_trap_req", 32'(trap_req_o), 32'(m_mode == 1));
         check("model_ready", 32'(ready_o), 32'(m_mode == 0));
         check("model_cause", 32'(trap_cause_o), 32'(m_cause));
         check("model_cnt", 32'(cnt_o), exp_cnt);
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic send(input int cls, input bit [2:0] en, input bit [3:0] r1,
                       input bit [3:0] r2, input bit [3:0] rd, input bit [3:0] mask,
                       input bit tm, input bit fl);
      instr_valid_i = 1'b1;
      instr_class_i = CW'(cls);
      chk_en_i      = '0;
      if (cls < NC) chk_en_i[3*cls +: 3] = en;
      tag_rs1_i = r1; tag_rs2_i = r2; tag_rd_i = rd; tag_mask_i = mask;
      trap_mode_i = tm;
      flush_i = fl;
      @(negedge clk);
      instr_valid_i = 1'b0;
      flush_i = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cnt_sel_i = 3'd3;
      #1;
      check("reset_ready", 32'(ready_o), 1);
      check("reset_trap_req", 32'(trap_req_o), 0);
      check("reset_violation", 32'(violation_o), 0);
      check("reset_cnt", 32'(cnt_o), 0);

      // INT class, S2 tainted, trap mode
      @(negedge clk);
      send(3, 3'b110, 4'h0, 4'h2, 4'h0, 4'hF, 1'b1, 1'b0);
      check("trap_no_early_pulse", 32'(violation_o), 0);
      @(negedge clk);
      check("trap_violation", 32'(violation_o), 1);
      check("trap_req_up", 32'(trap_req_o), 1);
      check("trap_ready_low", 32'(ready_o), 0);
      check("trap_cause", 32'(trap_cause_o), 32'h1A);
      trap_mode_i = 1'b0;
      repeat (3) @(negedge clk);
      check("trap_held", 32'(trap_req_o), 1);
      check("trap_pulse_once", 32'(violation_o), 0);
      check("trap_cause_frozen", 32'(trap_cause_o), 32'h1A);
      trap_ack_i = 1'b1;
      @(negedge clk);
      trap_ack_i = 1'b0;
      check("recover_req_low", 32'(trap_req_o), 0);
      check("recover_ready_low", 32'(ready_o), 0);
      @(negedge clk);
      check("recover_done_ready", 32'(ready_o), 1);
      check("trap_counted", 32'(cnt_o), 1);
      cnt_clr_i = 1'b1;
      @(negedge clk);
      cnt_clr_i = 1'b0;
      check("cnt_cleared", 32'(cnt_o), 0);

      // Same stimulus, count-only
      send(3, 3'b110, 4'h0, 4'h2, 4'h0, 4'hF, 1'b0, 1'b0);
      @(negedge clk);
      check("count_violation", 32'(violation_o), 1);
      check("count_no_trap", 32'(trap_req_o), 0);
      check("count_ready", 32'(ready_o), 1);
      check("count_cnt", 32'(cnt_o), 1);

      // Masked-out taint and disabled destination check
      send(3, 3'b110, 4'h0, 4'h2, 4'h0, 4'h1, 1'b0, 1'b0);
      @(negedge clk);
      check("mask_no_viol", 32'(violation_o), 0);
      send(3, 3'b011, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0);
      @(negedge clk);
      check("rd_disabled_no_viol", 32'(violation_o), 0);

      // Flush in the capture cycle
      send(3, 3'b110, 4'h0, 4'h2, 4'h0, 4'hF, 1'b0, 1'b1);
      @(negedge clk);
      check("flush_no_viol", 32'(violation_o), 0);
      check("flush_cnt_same", 32'(cnt_o), 1);

      // Clear and increment of the same counter in one cycle
      send(3, 3'b110, 4'h0, 4'h2, 4'h0, 4'hF, 1'b0, 1'b0);
      cnt_clr_i = 1'b1;
      @(negedge clk);
      cnt_clr_i = 1'b0;
      check("clr_inc_viol", 32'(violation_o), 1);
      check("clr_beats_inc", 32'(cnt_o), 0);

      // Classes beyond NUM_CLASSES with everything enabled and tainted
      for (int cls = NC; cls < 8; cls++) begin
         instr_valid_i = 1'b1;
         instr_class_i = CW'(cls);
         chk_en_i = '1;
         tag_rs1_i = 4'hF; tag_rs2_i = 4'hF; tag_rd_i = 4'hF; tag_mask_i = 4'hF;
         @(negedge clk);
         instr_valid_i = 1'b0;
         @(negedge clk);
         check("bad_class_no_viol", 32'(violation_o), 0);
         cnt_sel_i = CW'(cls);
         cnt_clr_i = 1'b1;
         #1;
         check("bad_class_cnt_zero", 32'(cnt_o), 0);
         @(negedge clk);
         cnt_clr_i = 1'b0;
      end

      // Saturation: back-to-back BRANCH violations
      cnt_sel_i = 3'd1;
      instr_valid_i = 1'b1;
      instr_class_i = 3'd1;
      chk_en_i = '0;
      chk_en_i[3 +: 3] = 3'b001;
      tag_rs1_i = 4'hF; tag_mask_i = 4'hF; trap_mode_i = 1'b0;
      repeat (CMAX + 5) @(negedge clk);
      instr_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      check("cnt_saturated", 32'(cnt_o), 32'hFFFF);

      // Reset in the middle of a trap
      send(3, 3'b110, 4'h0, 4'h2, 4'h0, 4'hF, 1'b1, 1'b0);
      @(negedge clk);
      check("pre_rst_trap", 32'(trap_req_o), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_trap_dropped", 32'(trap_req_o), 0);
      check("rst_ready", 32'(ready_o), 1);
      for (int s = 0; s < 8; s++) begin
         cnt_sel_i = CW'(s);
         #1;
         check("rst_cnt_zero", 32'(cnt_o), 0);
      end

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst           = ($urandom_range(0, 199) == 0);
         instr_valid_i = $urandom_range(0, 1);
         instr_class_i = CW'($urandom_range(0, 7));
         chk_en_i      = (3*NC)'($urandom);
         tag_rs1_i     = TW'($urandom);
         tag_rs2_i     = TW'($urandom);
         tag_rd_i      = TW'($urandom);
         tag_mask_i    = TW'($urandom);
         trap_mode_i   = $urandom_range(0, 1);
         flush_i       = ($urandom_range(0, 7) == 0);
         trap_ack_i    = ($urandom_range(0, 3) == 0);
         cnt_clr_i     = ($urandom_range(0, 15) == 0);
         cnt_sel_i     = CW'($urandom_range(0, 7));
      end
      @(negedge clk);
      rst = 1'b0; instr_valid_i = 1'b0; flush_i = 1'b0; trap_ack_i = 1'b0; cnt_clr_i = 1'b0;
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
